// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-stage sequencer: control-word bit map, FSM states, SP reset value.
package mem_stage_pkg;

  localparam int CTRL_W      = 10;
  localparam int C_MEM_READ  = 0;
  localparam int C_MEM_WRITE = 1;
  localparam int C_PUSH      = 2;
  localparam int C_POP       = 3;
  localparam int C_CALL      = 4;
  localparam int C_RET       = 5;
  localparam int C_RTI       = 6;
  localparam int C_REG_WRITE = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH_LO,
    S_POP_HI,
    S_VEC_HI,
    S_VEC_LO
  } state_t;

  // Empty stack points at the top word of the data memory.
  function automatic logic [31:0] sp_reset_val(input int aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/mem_stage_seq_stack_ptr_unit.sv
// Stack pointer register with increment/decrement; with STACK_GUARD_EN defined, overflow/underflow
// accesses are refused and a sticky fault flag is raised.
module stack_ptr_unit
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_inc,
  output logic              push_ok,
  output logic              pop_ok,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] SP_RST = ADDR_W'(sp_reset_val(ADDR_W));

  assign sp_inc = sp + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= SP_RST;
    end else if (push && push_ok) begin
      sp <= sp - ADDR_W'(1);
    end else if (pop && pop_ok) begin
      sp <= sp_inc;
    end
  end

`ifdef STACK_GUARD_EN
  // A full stack sits at address 0, an empty one at the top word.
  assign push_ok = (sp != '0);
  assign pop_ok  = (sp != SP_RST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault <= 1'b0;
    end else if ((push && !push_ok) || (pop && !pop_ok)) begin
      fault <= 1'b1;
    end
  end
`else
  assign push_ok = 1'b1;
  assign pop_ok  = 1'b1;
  assign fault   = 1'b0;
`endif

endmodule

// File: rtl/mem_stage_seq.sv
// Memory-stage sequencer: data-memory access, stack ops, 2-beat PC push/pop and interrupt entry.
// Optional stack bounds checking is enabled with the STACK_GUARD_EN macro (inside stack_ptr_unit).
module mem_stage_seq
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int VEC_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [15:0]       alu_data_in,
  input  logic [15:0]       read_data2_in,
  input  logic [2:0]        write_add_in,
  input  logic [31:0]       pc_in,
  input  logic              interrupt_in,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              stall_out,
  output logic [15:0]       wb_data_out,
  output logic [2:0]        write_add_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              stack_fault
);

  localparam logic [ADDR_W-1:0] VEC_HI_A = ADDR_W'(VEC_ADDR);
  localparam logic [ADDR_W-1:0] VEC_LO_A = ADDR_W'(VEC_ADDR + 1);

  state_t            state, state_nxt;
  logic              int_pending, in_service, irq_entry;
  logic [15:0]       cap_q;
  logic [ADDR_W-1:0] sp, sp_inc;
  logic              push_req, pop_req, push_ok, pop_ok;
  logic              svc_start, svc_end, entry_done, cap_load;
  logic              we_c, re_c, stall_c, rv_c;
  logic              no_op;

  assign no_op = (ctrl_in[C_RTI:C_MEM_READ] == '0);

  stack_ptr_unit #(.ADDR_W(ADDR_W)) u_sp (
    .clk     (clk),
    .rst     (rst),
    .push    (push_req),
    .pop     (pop_req),
    .sp      (sp),
    .sp_inc  (sp_inc),
    .push_ok (push_ok),
    .pop_ok  (pop_ok),
    .fault   (stack_fault)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      int_pending <= 1'b0;
      in_service  <= 1'b0;
      irq_entry   <= 1'b0;
      cap_q       <= '0;
    end else begin
      state <= state_nxt;
      // A request arriving on the entry edge is kept rather than lost.
      int_pending <= (int_pending & ~svc_start) | interrupt_in;
      if (svc_start) begin
        in_service <= 1'b1;
      end else if (svc_end) begin
        in_service <= 1'b0;
      end
      if (svc_start) begin
        irq_entry <= 1'b1;
      end else if (entry_done) begin
        irq_entry <= 1'b0;
      end
      if (cap_load) begin
        cap_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    push_req    = 1'b0;
    pop_req     = 1'b0;
    cap_load    = 1'b0;
    svc_start   = 1'b0;
    svc_end     = 1'b0;
    entry_done  = 1'b0;
    we_c        = 1'b0;
    re_c        = 1'b0;
    stall_c     = 1'b0;
    rv_c        = 1'b0;
    mem_addr    = alu_data_in[ADDR_W-1:0];
    mem_wdata   = read_data2_in;
    wb_data_out = alu_data_in;
    redirect_pc = {mem_rdata, cap_q};
    unique case (state)
      S_IDLE: begin
        if (no_op && int_pending && !in_service) begin
          svc_start = 1'b1;
          push_req  = 1'b1;
          mem_addr  = sp;
          mem_wdata = pc_in[31:16];
          we_c      = push_ok;
          stall_c   = 1'b1;
          state_nxt = S_PUSH_LO;
        end else if (ctrl_in[C_RTI] || ctrl_in[C_RET]) begin
          pop_req   = 1'b1;
          mem_addr  = sp_inc;
          re_c      = pop_ok;
          cap_load  = 1'b1;
          stall_c   = 1'b1;
          state_nxt = S_POP_HI;
        end else if (ctrl_in[C_CALL]) begin
          push_req  = 1'b1;
          mem_addr  = sp;
          mem_wdata = pc_in[31:16];
          we_c      = push_ok;
          stall_c   = 1'b1;
          state_nxt = S_PUSH_LO;
        end else if (ctrl_in[C_POP]) begin
          pop_req     = 1'b1;
          mem_addr    = sp_inc;
          re_c        = pop_ok;
          wb_data_out = mem_rdata;
        end else if (ctrl_in[C_PUSH]) begin
          push_req = 1'b1;
          mem_addr = sp;
          we_c     = push_ok;
        end else if (ctrl_in[C_MEM_WRITE]) begin
          we_c = 1'b1;
        end else if (ctrl_in[C_MEM_READ]) begin
          re_c        = 1'b1;
          wb_data_out = mem_rdata;
        end
      end
      S_PUSH_LO: begin
        push_req  = 1'b1;
        mem_addr  = sp;
        mem_wdata = pc_in[15:0];
        we_c      = push_ok;
        if (irq_entry) begin
          stall_c   = 1'b1;
          state_nxt = S_VEC_HI;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_POP_HI: begin
        pop_req   = 1'b1;
        mem_addr  = sp_inc;
        re_c      = pop_ok;
        rv_c      = 1'b1;
        svc_end   = ctrl_in[C_RTI];
        state_nxt = S_IDLE;
      end
      S_VEC_HI: begin
        mem_addr  = VEC_HI_A;
        re_c      = 1'b1;
        cap_load  = 1'b1;
        stall_c   = 1'b1;
        state_nxt = S_VEC_LO;
      end
      S_VEC_LO: begin
        mem_addr    = VEC_LO_A;
        re_c        = 1'b1;
        rv_c        = 1'b1;
        redirect_pc = {cap_q, mem_rdata};
        entry_done  = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_out = ctrl_in;
    if (stall_c) begin
      ctrl_out[C_REG_WRITE] = 1'b0;
    end
    if (rst) begin
      ctrl_out = '0;
    end
  end

  assign mem_we         = we_c & ~rst;
  assign mem_re         = re_c & ~rst;
  assign stall_out      = stall_c & ~rst;
  assign redirect_valid = rv_c & ~rst;
  assign write_add_out  = write_add_in;

endmodule

// File: tb/tb_mem_stage_seq.sv
// Scoreboard bench for mem_stage_seq: an instruction-level model expands each issued instruction
// into its expected per-cycle beats; a monitor compares one beat per cycle against the DUT.
module tb_mem_stage_seq;

  localparam int AW  = 11;
  localparam int VEC = 0;

  typedef struct packed {
    logic        we, re, stall, rv, fault;
    logic [9:0]  ctrl;
    logic [15:0] wb;
    logic [2:0]  wa;
    logic [10:0] addr;
    logic [15:0] wdata;
    logic [31:0] rpc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  ctrl_in = '0;
  logic [15:0] alu_data_in = '0, read_data2_in = '0;
  logic [2:0]  write_add_in = '0;
  logic [31:0] pc_in = '0;
  logic        interrupt_in = 1'b0;
  logic [15:0] mem_rdata;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata, wb_data_out;
  logic        mem_we, mem_re, stall_out, redirect_valid, stack_fault;
  logic [2:0]  write_add_out;
  logic [9:0]  ctrl_out;
  logic [31:0] redirect_pc;

  mem_stage_seq #(.ADDR_W(AW), .VEC_ADDR(VEC)) dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .alu_data_in(alu_data_in),
    .read_data2_in(read_data2_in), .write_add_in(write_add_in), .pc_in(pc_in),
    .interrupt_in(interrupt_in), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .stall_out(stall_out),
    .wb_data_out(wb_data_out), .write_add_out(write_add_out), .ctrl_out(ctrl_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stack_fault(stack_fault)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT
  logic [15:0] tmem [0:2047] = '{default: 16'h0000};
  always @(posedge clk) if (mem_we) tmem[mem_addr] <= mem_wdata;
  assign mem_rdata = tmem[mem_addr];

  // Reference model state
  logic [15:0] rmem [0:2047] = '{default: 16'h0000};
  logic [10:0] msp = 11'h7FF;
  bit          mpend, minsvc, mfault;
  logic [9:0]  m_c;
  logic [15:0] m_alu, m_rd2;
  logic [2:0]  m_wa;
  logic [31:0] m_pc;
  bit          m_irq;
  int          m_n;

  beat_t exp_q[$];
  int    checks = 0, errors = 0, beat_no = 0;
  bit    mon_en = 1'b0;

  task automatic emit(input bit we, re, stall, rv, input logic [10:0] addr,
                      input logic [15:0] wdata, wb, input logic [31:0] rpc);
    beat_t b;
    b = '0;
    b.we = we; b.re = re; b.stall = stall; b.rv = rv; b.fault = mfault;
    b.ctrl = stall ? (m_c & ~10'h080) : m_c;
    b.wb = wb; b.wa = m_wa; b.addr = addr; b.wdata = wdata; b.rpc = rpc;
    exp_q.push_back(b);
    if (we) rmem[addr] = wdata;
    mpend = mpend | m_irq;
    m_n++;
  endtask

  task automatic m_push(input logic [15:0] d, input bit stall);
    bit ok = 1'b1;
`ifdef STACK_GUARD_EN
    ok = (msp != 11'd0);
`endif
    emit(ok, 1'b0, stall, 1'b0, msp, d, m_alu, 32'h0);
    if (ok) msp = msp - 11'd1; else mfault = 1'b1;
  endtask

  task automatic m_pop(input bit stall, rv, use_wb, input logic [15:0] lo, output logic [15:0] d);
    bit ok = 1'b1;
    logic [10:0] a;
    a = msp + 11'd1;
`ifdef STACK_GUARD_EN
    ok = (msp != 11'h7FF);
`endif
    d = rmem[a];
    emit(1'b0, ok, stall, rv, a, 16'h0, use_wb ? d : m_alu, {d, lo});
    if (ok) msp = a; else mfault = 1'b1;
  endtask

  task automatic model_instr(output int n);
    logic [15:0] lo, hi, vhi;
    logic [10:0] ea;
    ea = m_alu[10:0];
    m_n = 0;
    if (m_c[6:0] == 7'd0 && mpend && !minsvc) begin
      mpend = 1'b0; minsvc = 1'b1;
      m_push(m_pc[31:16], 1'b1);
      m_push(m_pc[15:0], 1'b1);
      vhi = rmem[VEC];
      emit(1'b0, 1'b1, 1'b1, 1'b0, 11'(VEC), 16'h0, m_alu, 32'h0);
      emit(1'b0, 1'b1, 1'b0, 1'b1, 11'(VEC + 1), 16'h0, m_alu, {vhi, rmem[VEC + 1]});
    end else if (m_c[6] || m_c[5]) begin
      m_pop(1'b1, 1'b0, 1'b0, 16'h0, lo);
      m_pop(1'b0, 1'b1, 1'b0, lo, hi);
      if (m_c[6]) minsvc = 1'b0;
    end else if (m_c[4]) begin
      m_push(m_pc[31:16], 1'b1);
      m_push(m_pc[15:0], 1'b0);
    end else if (m_c[3]) begin
      m_pop(1'b0, 1'b0, 1'b1, 16'h0, lo);
    end else if (m_c[2]) begin
      m_push(m_rd2, 1'b0);
    end else if (m_c[1]) begin
      emit(1'b1, 1'b0, 1'b0, 1'b0, ea, m_rd2, m_alu, 32'h0);
    end else if (m_c[0]) begin
      emit(1'b0, 1'b1, 1'b0, 1'b0, ea, 16'h0, rmem[ea], 32'h0);
    end else begin
      emit(1'b0, 1'b0, 1'b0, 1'b0, 11'h0, 16'h0, m_alu, 32'h0);
    end
    n = m_n;
  endtask

  // Inputs stay held for every beat of the instruction, as a frozen E/M buffer would.
  task automatic issue(input logic [9:0] c, input logic [15:0] alu, rd2,
                       input logic [2:0] wa, input logic [31:0] pc, input bit irq);
    int n;
    ctrl_in = c; alu_data_in = alu; read_data2_in = rd2;
    write_add_in = wa; pc_in = pc; interrupt_in = irq;
    m_c = c; m_alu = alu; m_rd2 = rd2; m_wa = wa; m_pc = pc; m_irq = irq;
    model_instr(n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_we, mem_re, stall_out, redirect_valid, stack_fault} !== 5'b0 || ctrl_out !== 10'h0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b re=%b stall=%b rv=%b fault=%b ctrl=%h, required all zero",
               mem_we, mem_re, stall_out, redirect_valid, stack_fault, ctrl_out);
    end
    repeat (2) @(posedge clk);
    #1;
    ctrl_in = '0; interrupt_in = 1'b0;
    rst = 1'b0;
    msp = 11'h7FF; mpend = 1'b0; minsvc = 1'b0; mfault = 1'b0;
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      beat_t e;
      bit ok;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_underflow: DUT cycle %0d has no expected beat queued", beat_no);
      end else begin
        e = exp_q.pop_front();
        ok = (mem_we === e.we) && (mem_re === e.re) && (stall_out === e.stall) &&
             (redirect_valid === e.rv) && (ctrl_out === e.ctrl) && (wb_data_out === e.wb) &&
             (write_add_out === e.wa) && (stack_fault === e.fault);
        if (e.we || e.re) ok = ok && (mem_addr === e.addr);
        if (e.we) ok = ok && (mem_wdata === e.wdata);
        if (e.rv) ok = ok && (redirect_pc === e.rpc);
        if (!ok) begin
          errors++;
          $display("FAIL beat %0d: got we=%b re=%b stall=%b rv=%b ctrl=%h wb=%h wa=%h fault=%b addr=%h wdata=%h rpc=%h | required we=%b re=%b stall=%b rv=%b ctrl=%h wb=%h wa=%h fault=%b addr=%h wdata=%h rpc=%h",
                   beat_no, mem_we, mem_re, stall_out, redirect_valid, ctrl_out, wb_data_out,
                   write_add_out, stack_fault, mem_addr, mem_wdata, redirect_pc,
                   e.we, e.re, e.stall, e.rv, e.ctrl, e.wb, e.wa, e.fault, e.addr, e.wdata, e.rpc);
        end
      end
      beat_no++;
    end
  end

  initial begin
    logic [9:0]  c;
    logic [15:0] alu;
    logic [10:0] saved_sp;
    int          sel;

    #2;
    ctrl_in = 10'h3FF;
    do_reset();

    // Store then load
    issue(10'h002, 16'h0010, 16'hBEEF, 3'd1, 32'h0, 1'b0);
    issue(10'h081, 16'h0010, 16'h0000, 3'd2, 32'h0, 1'b0);
    // Push then pop from an empty stack
    issue(10'h004, 16'h0000, 16'h1234, 3'd0, 32'h0, 1'b0);
    issue(10'h088, 16'h0000, 16'h0000, 3'd3, 32'h0, 1'b0);
    // Call and return
    issue(10'h010, 16'h0000, 16'h0000, 3'd0, 32'h0001_0040, 1'b0);
    issue(10'h020, 16'h0000, 16'h0000, 3'd0, 32'h0, 1'b0);
    // Interrupt vector contents
    issue(10'h002, 16'h0000, 16'h0000, 3'd0, 32'h0, 1'b0);
    issue(10'h002, 16'h0001, 16'h0100, 3'd0, 32'h0, 1'b0);
    // Interrupt entry, second request held until RTI
    issue(10'h080, 16'h1111, 16'h0000, 3'd4, 32'h0000_0020, 1'b1);
    issue(10'h080, 16'h2222, 16'h0000, 3'd5, 32'h0000_0022, 1'b0);
    issue(10'h000, 16'h3333, 16'h0000, 3'd0, 32'h0000_0100, 1'b1);
    issue(10'h000, 16'h4444, 16'h0000, 3'd0, 32'h0000_0101, 1'b0);
    issue(10'h000, 16'h5555, 16'h0000, 3'd0, 32'h0000_0102, 1'b0);
    issue(10'h040, 16'h0000, 16'h0000, 3'd0, 32'h0000_0103, 1'b0);
    issue(10'h000, 16'h6666, 16'h0000, 3'd0, 32'h0000_0022, 1'b0);
    issue(10'h040, 16'h0000, 16'h0000, 3'd0, 32'h0000_0104, 1'b0);
    // Interrupt arriving with a load
    issue(10'h081, 16'h0001, 16'h0000, 3'd6, 32'h0000_0030, 1'b1);
    issue(10'h080, 16'h7777, 16'h0000, 3'd7, 32'h0000_0031, 1'b0);
    issue(10'h040, 16'h0000, 16'h0000, 3'd0, 32'h0000_0105, 1'b0);

    // Randomised instruction stream including multi-bit control words
    for (int i = 0; i < 400; i++) begin
      c = 10'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 3) c[6:0] = 7'd0;
      else if (sel < 9) c[6:0] = 7'(1 << $urandom_range(0, 6));
      alu = 16'($urandom);
      alu[10:5] = 6'd0;
      issue(c, alu, 16'($urandom), 3'($urandom), $urandom, ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a CALL: the high word already written must survive
    mon_en = 1'b0;
    ctrl_in = 10'h010; pc_in = 32'hABCD_1234; interrupt_in = 1'b0;
    @(posedge clk);
    saved_sp = msp;
    rmem[msp] = 16'hABCD;
    #2;
    do_reset();
    issue(10'h081, {5'd0, saved_sp}, 16'h0000, 3'd1, 32'h0, 1'b0);
    issue(10'h004, 16'h0000, 16'h5A5A, 3'd0, 32'h0, 1'b0);
    issue(10'h081, 16'h07FF, 16'h0000, 3'd2, 32'h0, 1'b0);

`ifdef STACK_GUARD_EN
    ctrl_in = 10'h3FF;
    do_reset();
    for (int i = 0; i < 2049; i++) issue(10'h004, 16'h0000, 16'(i), 3'd0, 32'h0, 1'b0);
    issue(10'h000, 16'h0000, 16'h0000, 3'd0, 32'h0, 1'b0);
`endif

    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL beat_drain: %0d expected beats never observed, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
